// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: upstream (register-read) and downstream (ALU) handshake
// bundle for the ALU issue stage. The stage is the slave side; the producer of
// instructions and consumer of operands (or a testbench) is the master side.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    // branch redirect
    logic            flush;

    // upstream: instruction plus register-file values
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;

    // downstream: decoded ALU operands
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_A;
    logic [XLEN-1:0] out_B;
    logic [1:0]      out_ALUOp;
    logic [4:0]      out_rd;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_rs1_val, in_rs2_val, out_ready,
        input  in_ready, out_valid, out_A, out_B, out_ALUOp, out_rd, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_rs1_val, in_rs2_val, out_ready,
        output in_ready, out_valid, out_A, out_B, out_ALUOp, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I ALU instructions into operand A/B, a 2-bit
// ALU op and rd, and hands them to execute through a 2-entry skid buffer
// (main entry drives the outputs, skid entry absorbs one overflow) so that
// in_ready can be a flop while still sustaining one instruction per cycle.
// Optional build macro: ALU_ISSUE_LUI_EN -- decode LUI as a legal ADD 0+imm.
// Only XLEN = 32 is supported.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_stage_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [1:0]      op;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    entry_t main_q, main_n;
    entry_t skid_q, skid_n;
    logic   main_vld, main_vld_n;
    logic   skid_vld, skid_vld_n;
    logic   in_ready_q;

    entry_t          dec;
    logic            dec_legal;
    logic [1:0]      dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic accept;
    logic consume;

    // rs1 field is never needed: the register value arrives already read
    logic unused_rs1_field;
    assign unused_rs1_field = ^bus.in_instr[19:15];

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];
    assign funct7 = bus.in_instr[31:25];

    assign accept  = bus.in_valid && in_ready_q;
    assign consume = main_vld && bus.out_ready;

    // Decode the presented instruction; unsupported encodings become an
    // all-zero payload with the illegal flag set.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        dec_a     = bus.in_rs1_val;
        dec_b     = bus.in_rs2_val;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  begin dec_legal = 1'b1; dec_op = ALU_ADD; end
                        3'b111:  begin dec_legal = 1'b1; dec_op = ALU_AND; end
                        3'b110:  begin dec_legal = 1'b1; dec_op = ALU_OR;  end
                        default: dec_legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SUB;
                end
            end
            OPC_OP_IMM: begin
                dec_b = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
                case (funct3)
                    3'b000:  begin dec_legal = 1'b1; dec_op = ALU_ADD; end
                    3'b111:  begin dec_legal = 1'b1; dec_op = ALU_AND; end
                    3'b110:  begin dec_legal = 1'b1; dec_op = ALU_OR;  end
                    default: dec_legal = 1'b0;
                endcase
            end
`ifdef ALU_ISSUE_LUI_EN
            OPC_LUI: begin
                // LUI rides the adder as 0 + (imm << 12)
                dec_legal = 1'b1;
                dec_op    = ALU_ADD;
                dec_a     = '0;
                dec_b     = XLEN'({bus.in_instr[31:12], 12'b0});
            end
`else
            OPC_LUI: dec_legal = 1'b0;
`endif
            default: dec_legal = 1'b0;
        endcase

        dec.illegal = !dec_legal;
        dec.op      = dec_legal ? dec_op : ALU_ADD;
        dec.a       = dec_legal ? dec_a : '0;
        dec.b       = dec_legal ? dec_b : '0;
        dec.rd      = dec_legal ? bus.in_instr[11:7] : 5'd0;
    end

    // Skid-buffer next state: flush wins over everything, then either the
    // main slot refills (from skid first, else from input) or, when main is
    // stalled, an accepted input parks in skid.
    always_comb begin
        main_n     = main_q;
        main_vld_n = main_vld;
        skid_n     = skid_q;
        skid_vld_n = skid_vld;
        if (bus.flush) begin
            main_vld_n = 1'b0;
            skid_vld_n = 1'b0;
        end else if (!main_vld || consume) begin
            if (skid_vld) begin
                main_n     = skid_q;
                main_vld_n = 1'b1;
                skid_vld_n = accept;
                if (accept) skid_n = dec;
            end else begin
                main_vld_n = accept;
                if (accept) main_n = dec;
            end
        end else if (accept) begin
            skid_n     = dec;
            skid_vld_n = 1'b1;
        end
    end

    // State registers; in_ready is registered off the next skid occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_n;
            skid_q     <= skid_n;
            main_vld   <= main_vld_n;
            skid_vld   <= skid_vld_n;
            in_ready_q <= !skid_vld_n;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = main_vld;
    assign bus.out_A       = main_q.a;
    assign bus.out_B       = main_q.b;
    assign bus.out_ALUOp   = main_q.op;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed test-plan steps followed by a randomized run,
// all checked against a FIFO-of-capacity-2 reference model whose entries are
// decoded straight from the instruction tables.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    // Reference decode written from the instruction tables.
    function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2);
        exp_t        e;
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        logic [31:0] simm = {{20{ins[31]}}, ins[31:20]};
        e = '{a: 32'd0, b: 32'd0, op: 2'd0, rd: 5'd0, ill: 1'b1};
        if (opc == 7'h33) begin
            if      (f7 == 7'h00 && f3 == 3'd0) e = '{r1, r2, 2'd0, ins[11:7], 1'b0};
            else if (f7 == 7'h20 && f3 == 3'd0) e = '{r1, r2, 2'd1, ins[11:7], 1'b0};
            else if (f7 == 7'h00 && f3 == 3'd7) e = '{r1, r2, 2'd2, ins[11:7], 1'b0};
            else if (f7 == 7'h00 && f3 == 3'd6) e = '{r1, r2, 2'd3, ins[11:7], 1'b0};
        end else if (opc == 7'h13) begin
            if      (f3 == 3'd0) e = '{r1, simm, 2'd0, ins[11:7], 1'b0};
            else if (f3 == 3'd7) e = '{r1, simm, 2'd2, ins[11:7], 1'b0};
            else if (f3 == 3'd6) e = '{r1, simm, 2'd3, ins[11:7], 1'b0};
        end
`ifdef ALU_ISSUE_LUI_EN
        else if (opc == 7'h37) e = '{32'd0, ins & 32'hFFFFF000, 2'd0, ins[11:7], 1'b0};
`endif
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Compare DUT outputs against the model queue: head of queue is main.
    task automatic model_check();
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
        if (q.size() != 0) begin
            chk("out_A",       bus.out_A,               q[0].a);
            chk("out_B",       bus.out_B,               q[0].b);
            chk("out_ALUOp",   32'(bus.out_ALUOp),      32'(q[0].op));
            chk("out_rd",      32'(bus.out_rd),         32'(q[0].rd));
            chk("out_illegal", 32'(bus.out_illegal),    32'(q[0].ill));
        end
    endtask

    // One clock: drive, update model on the edge, check 1ns later.
    task automatic step(bit v, logic [31:0] ins, logic [31:0] r1, logic [31:0] r2,
                        bit ordy, bit fl, bit rs);
        bit rdy_exp;
        bus.in_valid   = v;
        bus.in_instr   = ins;
        bus.in_rs1_val = r1;
        bus.in_rs2_val = r2;
        bus.out_ready  = ordy;
        bus.flush      = fl;
        rst            = rs;
        rdy_exp        = (q.size() < 2);
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
        end else begin
            if (ordy && q.size() != 0) void'(q.pop_front());
            if (v && rdy_exp) q.push_back(ref_decode(ins, r1, r2));
        end
        #1;
        model_check();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [31:0] ins;
        int sel = $urandom_range(0, 3);
        logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h00, 7'h00};
        logic [2:0] f3s[4] = '{3'd0, 3'd0, 3'd7, 3'd6};
        logic [2:0] f3i[3] = '{3'd0, 3'd7, 3'd6};
        case ($urandom_range(0, 6))
            0: ins = {f7s[sel], r[24:13], f3s[sel], r[11:7], 7'h33};
            1: ins = {r[31:15], r[14:12], r[11:7], 7'h33};
            2: ins = {r[31:15], f3i[sel % 3], r[11:7], 7'h13};
            3: ins = {r[31:15], r[14:12], r[11:7], 7'h13};
            4: ins = {r[31:7], 7'h37};
            5: ins = r;
            default: ins = 32'h00000073;
        endcase
        return ins;
    endfunction

    initial begin
        bus.in_valid = 0; bus.in_instr = 0; bus.in_rs1_val = 0; bus.in_rs2_val = 0;
        bus.out_ready = 0; bus.flush = 0;

        // reset and idle
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.in_ready),  32'd1);
        chk("rst_op",    32'(bus.out_ALUOp), 32'd0);
        chk("rst_A",     bus.out_A,          32'd0);
        chk("rst_B",     bus.out_B,          32'd0);
        chk("rst_rd",    32'(bus.out_rd),    32'd0);
        chk("rst_ill",   32'(bus.out_illegal), 32'd0);

        // ADD / SUB / ADDI / ORI back-to-back
        step(1, 32'h002081B3, 5, 7, 1, 0, 0);
        chk("add_A", bus.out_A, 32'd5);
        chk("add_B", bus.out_B, 32'd7);
        chk("add_op", 32'(bus.out_ALUOp), 32'd0);
        chk("add_rd", 32'(bus.out_rd), 32'd3);
        step(1, 32'h402081B3, 5, 7, 1, 0, 0);
        chk("sub_op", 32'(bus.out_ALUOp), 32'd1);
        step(1, 32'hFFF00093, 0, 9, 1, 0, 0);
        chk("addi_B", bus.out_B, 32'hFFFFFFFF);
        chk("addi_rd", 32'(bus.out_rd), 32'd1);
        step(1, 32'h0FF0E093, 3, 9, 1, 0, 0);
        chk("ori_B", bus.out_B, 32'h000000FF);
        chk("ori_op", 32'(bus.out_ALUOp), 32'd3);
        chk("ori_valid", 32'(bus.out_valid), 32'd1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // backpressure: 3 pushed, 2 held, third waits
        step(1, 32'h00208533, 1, 2, 0, 0, 0);
        chk("bp1_rd", 32'(bus.out_rd), 32'd10);
        step(1, 32'h00500593, 3, 4, 0, 0, 0);
        chk("bp2_ready", 32'(bus.in_ready), 32'd0);
        chk("bp2_rd", 32'(bus.out_rd), 32'd10);
        step(1, 32'h00106613, 5, 6, 0, 0, 0);
        chk("bp3_rd", 32'(bus.out_rd), 32'd10);
        step(1, 32'h00106613, 5, 6, 1, 0, 0);
        chk("rel1_rd", 32'(bus.out_rd), 32'd11);
        chk("rel1_ready", 32'(bus.in_ready), 32'd1);
        step(1, 32'h00106613, 5, 6, 1, 0, 0);
        chk("rel2_rd", 32'(bus.out_rd), 32'd12);
        step(0, 0, 0, 0, 1, 0, 0);

        // flush with both entries full, plus a discarded input
        step(1, 32'h00208533, 1, 2, 0, 0, 0);
        step(1, 32'h00500593, 3, 4, 0, 0, 0);
        step(1, 32'h00106693, 5, 6, 0, 1, 0);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_ready", 32'(bus.in_ready), 32'd1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("flush_gone", 32'(bus.out_valid), 32'd0);

        // LUI and ECALL
        step(1, 32'h123452B7, 32'hAAAA, 32'h5555, 1, 0, 0);
`ifdef ALU_ISSUE_LUI_EN
        chk("lui_B",   bus.out_B, 32'h12345000);
        chk("lui_A",   bus.out_A, 32'd0);
        chk("lui_rd",  32'(bus.out_rd), 32'd5);
        chk("lui_ill", 32'(bus.out_illegal), 32'd0);
`else
        chk("lui_ill", 32'(bus.out_illegal), 32'd1);
        chk("lui_A",   bus.out_A, 32'd0);
        chk("lui_B",   bus.out_B, 32'd0);
`endif
        step(1, 32'h00000073, 32'h1234, 32'h5678, 1, 0, 0);
        chk("ecall_ill", 32'(bus.out_illegal), 32'd1);
        chk("ecall_A", bus.out_A, 32'd0);
        chk("ecall_rd", 32'(bus.out_rd), 32'd0);

        // reset mid-stall
        step(1, 32'h00208533, 1, 2, 0, 0, 0);
        step(1, 32'h00500593, 3, 4, 0, 0, 0);
        step(1, 32'h00106693, 5, 6, 0, 1, 1);
        chk("rstall_valid", 32'(bus.out_valid), 32'd0);
        chk("rstall_ready", 32'(bus.in_ready), 32'd1);
        chk("rstall_A", bus.out_A, 32'd0);
        step(0, 0, 0, 0, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit ordy = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, ordy,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 300) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX-side producer for the 2-bit-opcode ALU: decodes RV32I instructions into ALU operands A/B and the 2-bit ALU op, and registers them toward the execute stage.
- Sits between register-file read (upstream) and the ALU (downstream).
- Uses a valid/ready handshake on both sides.
- A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- XLEN, 32, operand/data width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  drop all held entries (branch redirect)
- in_valid  input  1  upstream holds a valid instruction
- in_ready  output  1  stage can accept this cycle
- in_instr  input  32  raw RV32I instruction
- in_rs1_val  input  XLEN  rs1 register value
- in_rs2_val  input  XLEN  rs2 register value
- out_valid  output  1  A/B/ALUOp/rd valid toward ALU
- out_ready  input  1  execute stage consumes this cycle
- out_A  output  XLEN  ALU operand A
- out_B  output  XLEN  ALU operand B
- out_ALUOp  output  2  00 ADD, 01 SUB, 10 AND, 11 OR
- out_rd  output  5  destination register index
- out_illegal  output  1  instruction not supported by this stage

Behaviour:
- Reset: out_valid=0, in_ready=1, out_A=0, out_B=0, out_ALUOp=00, out_rd=0, out_illegal=0; both buffer entries empty.
- Transfer rules:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - Payload must stay stable while out_valid && !out_ready.
- Decode (combinational on in_instr, registered on accept):
  - R-type, opcode 0110011:
    - funct3 000 + funct7 0000000 -> ADD (00)
    - funct3 000 + funct7 0100000 -> SUB (01)
    - funct3 111 + funct7 0 -> AND (10)
    - funct3 110 + funct7 0 -> OR (11)
    - A=rs1_val, B=rs2_val.
  - I-type, opcode 0010011:
    - funct3 000 -> ADDI (00); 111 -> ANDI (10); 110 -> ORI (11)
    - A=rs1_val; B = instr[31:20] sign-extended to XLEN.
  - rd = instr[11:7] for all decodes.
  - Anything else: out_illegal=1, ALUOp=00, A=0, B=0, rd=0. The entry still flows through the handshake like a legal one.
- Storage:
  - main entry drives the outputs; skid entry holds an overflow.
  - in_ready is a register: in_ready = !skid_valid.
- Latency: 1 cycle from accept to out_valid when main is empty or draining in the same cycle.
- Per-cycle update:
  - main empty or consumed, skid empty: accepted input -> main.
  - main empty or consumed, skid full: skid -> main; skid takes the accepted input if any (cannot occur, since in_ready=0).
  - main held (!out_ready): accepted input -> skid; in_ready drops next cycle.
  - Simultaneous accept and consume with main full, skid empty: input replaces main; no bubble.
- Throughput: 1 instruction/cycle sustained when out_ready=1.
- Empty: out_valid=0; out_* hold their last value (don't-care to consumer).
- Full (both entries): in_ready=0 until main drains.
- Flush:
  - Next cycle, both entries invalid, out_valid=0, in_ready=1.
  - An input presented on the flush cycle is discarded.
  - Flush takes priority over accept and over skid promotion.
- rst has priority over flush. Reset asserted mid-stall discards all entries.

Optional Feature:
- Macro ALU_ISSUE_LUI_EN.
- Defined: opcode 0110111 (LUI) decodes legal, with A=0, B={instr[31:12],12'b0}, ALUOp=00, rd=instr[11:7].
- Undefined: LUI decodes as illegal (out_illegal=1, A=B=0, rd=0).
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then idle -> out_valid=0, in_ready=1, out_ALUOp=00, out_A=0.
- Issue 0x002081B3 (ADD x3,x1,x2) with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, A=5, B=7, ALUOp=00, rd=3.
  - Then 0x402081B3 -> ALUOp=01.
- Back-to-back stream:
  - 0xFFF00093 (ADDI x1,x0,-1), rs1=0 -> B=0xFFFFFFFF, ALUOp=00, rd=1.
  - 0x0FF0E093 (ORI x1,x1,0xFF) -> B=0x000000FF, ALUOp=11.
  - Required: one result per cycle.
- Backpressure:
  - Hold out_ready=0 and push 3 instructions -> 2 accepted, in_ready=0 from the cycle after the 2nd accept, main payload stable.
  - Release out_ready -> both drain in order, no loss or duplication, third then accepted.
- Flush with both entries full -> next cycle out_valid=0, in_ready=1; the input offered on the flush cycle never appears.
- LUI 0x123452B7:
  - With ALU_ISSUE_LUI_EN: A=0, B=0x12345000, ALUOp=00, rd=5, illegal=0.
  - Without it: out_illegal=1, A=B=0.
  - Either build: 0x00000073 (ECALL) -> illegal=1.
